// File: rtl/imm_stage.sv
// imm_stage: RISC-V immediate decoder feeding a DEPTH-entry FIFO with ready/valid on both sides
module imm_stage #(
  parameter int XLEN = 32,
  parameter int DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_immediate,
  output logic [6:0]      o_format,
  output logic            o_illegal,
  output logic [7:0]      o_illegal_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [6:0] SYS = 7'b1110011;
  logic [6:0] op, fmt;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm;
  logic ill, push, pop;
  logic [AW-1:0] rptr, wptr;
  logic [AW:0] count;
  logic [XLEN+7:0] mem [DEPTH];
  assign op = i_inst[6:0];
  assign fmt = {op == SYS && i_inst[14],
                op == 7'b1101111,
                op == 7'b0110111 || op == 7'b0010111,
                op == 7'b1100011,
                op == 7'b0100011,
                op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 || (op == SYS && !i_inst[14]),
                op == 7'b0110011};
  assign ill = fmt == 7'd0;
  always_comb begin
    imm32 = fmt[1] ? {{20{i_inst[31]}}, i_inst[31:20]} :
            fmt[2] ? {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]} :
            fmt[3] ? {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0} :
            fmt[4] ? {i_inst[31:12], 12'b0} :
            fmt[5] ? {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0} :
            32'd0;
    imm = fmt[6] ? XLEN'(i_inst[19:15]) : XLEN'($signed(imm32));
  end
  assign o_ready = count < FULL && !i_rst;
  assign o_valid = count != '0 && !i_rst;
  assign push = i_valid && o_ready;
  assign pop = o_valid && i_ready;
  assign {o_immediate, o_format, o_illegal} = o_valid ? mem[rptr] : '0;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      o_illegal_count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {imm, fmt, ill};
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= push && !pop ? count + 1'b1 : !push && pop ? count - 1'b1 : count;
      o_illegal_count <= push && ill && o_illegal_count != 8'hFF ? o_illegal_count + 8'd1 : o_illegal_count;
    end
  end
endmodule

// File: tb/tb_imm_stage.sv
// tb_imm_stage: scoreboard bench driving XLEN=32 and XLEN=64 instances with identical stimulus
module tb_imm_stage;
  logic clk = 0;
  logic i_rst = 1, i_valid = 0, i_ready = 0;
  logic [31:0] i_inst = 0;
  logic o_ready32, o_valid32, o_ill32, o_ready64, o_valid64, o_ill64;
  logic [31:0] o_imm32;
  logic [63:0] o_imm64;
  logic [6:0] o_fmt32, o_fmt64;
  logic [7:0] o_cnt32, o_cnt64;
  int checks = 0, errors = 0, ill_cnt = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  imm_stage #(.XLEN(32), .DEPTH(2)) dut32 (.i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready32),
    .i_inst(i_inst), .o_valid(o_valid32), .i_ready(i_ready), .o_immediate(o_imm32), .o_format(o_fmt32),
    .o_illegal(o_ill32), .o_illegal_count(o_cnt32));
  imm_stage #(.XLEN(64), .DEPTH(2)) dut64 (.i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready64),
    .i_inst(i_inst), .o_valid(o_valid64), .i_ready(i_ready), .o_immediate(o_imm64), .o_format(o_fmt64),
    .o_illegal(o_ill64), .o_illegal_count(o_cnt64));

  function automatic logic [6:0] ref_fmt(input logic [31:0] x);
    case (x[6:0])
      7'b0110011: return 7'd1 << 0;
      7'b0010011, 7'b0000011, 7'b1100111: return 7'd1 << 1;
      7'b1110011: return x[14] ? 7'd1 << 6 : 7'd1 << 1;
      7'b0100011: return 7'd1 << 2;
      7'b1100011: return 7'd1 << 3;
      7'b0110111, 7'b0010111: return 7'd1 << 4;
      7'b1101111: return 7'd1 << 5;
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_imm(input logic [31:0] x, input int xlen);
    longint v;
    longint neg12;
    logic [6:0] f;
    logic [63:0] r;
    f = ref_fmt(x);
    neg12 = x[31] ? 64'sd4096 : 64'sd0;
    if (f == 7'd2) v = longint'(x[31:20]) - neg12;
    else if (f == 7'd4) v = longint'(x[31:25]) * 32 + longint'(x[11:7]) - neg12;
    else if (f == 7'd8) v = longint'(x[7]) * 2048 + longint'(x[30:25]) * 32 + longint'(x[11:8]) * 2 - neg12;
    else if (f == 7'd16) v = longint'(x[30:12]) * 4096 - (x[31] ? 64'sh80000000 : 64'sd0);
    else if (f == 7'd32) v = longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048 + longint'(x[30:21]) * 2 - (x[31] ? 64'sd1048576 : 64'sd0);
    else if (f == 7'd64) v = longint'(x[19:15]);
    else v = 0;
    r = v;
    return xlen == 32 ? {32'd0, r[31:0]} : r;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] h;
    chk("valid32", 64'(o_valid32), 64'(!i_rst && q.size() != 0));
    chk("valid64", 64'(o_valid64), 64'(!i_rst && q.size() != 0));
    chk("ready32", 64'(o_ready32), 64'(!i_rst && q.size() < 2));
    chk("ready64", 64'(o_ready64), 64'(!i_rst && q.size() < 2));
    chk("icount32", 64'(o_cnt32), 64'(ill_cnt));
    chk("icount64", 64'(o_cnt64), 64'(ill_cnt));
    if (i_rst) begin
      chk("rst_imm32", 64'(o_imm32), 64'd0);
      chk("rst_imm64", o_imm64, 64'd0);
      chk("rst_fmt", 64'(o_fmt32), 64'd0);
      chk("rst_ill", 64'(o_ill32), 64'd0);
    end else if (q.size() != 0) begin
      h = q[0];
      chk("imm32", 64'(o_imm32), ref_imm(h, 32));
      chk("imm64", o_imm64, ref_imm(h, 64));
      chk("fmt32", 64'(o_fmt32), 64'(ref_fmt(h)));
      chk("fmt64", 64'(o_fmt64), 64'(ref_fmt(h)));
      chk("ill32", 64'(o_ill32), 64'(ref_fmt(h) == 7'd0));
      chk("ill64", 64'(o_ill64), 64'(ref_fmt(h) == 7'd0));
      if (i_ready) void'(q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [31:0] x, input logic rdy, input logic rst, output logic acc);
    i_valid = v;
    i_inst = x;
    i_ready = rdy;
    i_rst = rst;
    @(negedge clk);
    acc = v && o_ready32 && !rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      ill_cnt = 0;
    end else if (acc) begin
      q.push_back(x);
      if (ref_fmt(x) == 7'd0 && ill_cnt < 255) ill_cnt++;
    end
    #1;
  endtask

  task automatic push_until(input logic [31:0] x, input logic rdy);
    logic acc;
    acc = 0;
    for (int k = 0; k < 50 && !acc; k++) step(1, x, rdy, 0, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got not-accepted expected accepted for %h", x);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(0, 32'd0, 1, 0, acc);
  endtask

  initial begin : stim
    logic acc;
    logic [31:0] r, x;
    logic [6:0] ops[12];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001011, 7'b1110111};
    for (int k = 0; k < 3; k++) step(0, 32'd0, 1, 1, acc);
    push_until(32'hFFF00093, 1);
    push_until(32'hFE112E23, 1);
    push_until(32'hFE000CE3, 1);
    push_until(32'h123452B7, 1);
    push_until(32'h300FD073, 1);
    push_until(32'h800002B7, 1);
    push_until(32'h0000006F, 1);
    push_until(32'h00000033, 1);
    idle(3);
    step(1, 32'h00100093, 0, 0, acc);
    step(1, 32'h00200113, 0, 0, acc);
    step(1, 32'h00300193, 0, 0, acc);
    step(1, 32'h00300193, 0, 0, acc);
    push_until(32'h00300193, 1);
    idle(4);
    for (int k = 0; k < 300; k++) step(1, 32'h00000000, 1, 0, acc);
    idle(2);
    step(1, 32'h00500293, 0, 0, acc);
    step(1, 32'h00600313, 0, 0, acc);
    step(0, 32'd0, 0, 1, acc);
    push_until(32'h00700393, 1);
    idle(3);
    for (int k = 0; k < 3000; k++) begin
      r = $urandom();
      x = {r[31:7], ops[$urandom_range(0, 11)]};
      if ($urandom_range(0, 9) == 0) x = $urandom();
      step($urandom_range(0, 3) != 0, x, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0, acc);
    end
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_stage.md
IMM_STAGE -- requirements
Module: imm_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate width; legal values 32 and 64 only.
REQ-002 Parameter DEPTH, default 2, output buffer entries; power of two, at least 2.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_valid  input  1  upstream instruction valid.
REQ-006 o_ready  output  1  stage can accept an instruction this cycle.
REQ-007 i_inst  input  32  instruction word, sampled when i_valid and o_ready are both high.
REQ-008 o_valid  output  1  head entry valid.
REQ-009 i_ready  input  1  downstream accepts head entry.
REQ-010 o_immediate  output  XLEN  decoded, extended immediate of head entry.
REQ-011 o_format  output  7  one-hot format of head entry: [0] R, [1] I, [2] S, [3] B, [4] U, [5] J, [6] CSR-immediate.
REQ-012 o_illegal  output  1  head entry opcode is unrecognised.
REQ-013 o_illegal_count  output  8  saturating count of illegal instructions accepted.

Function
REQ-014 The format SHALL be decoded internally from i_inst[6:0]: 0110011 R; 0010011, 0000011, 1100111 I; 1110011 with i_inst[14]=0 I; 1110011 with i_inst[14]=1 CSR-imm; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J.
REQ-015 Any other opcode, including i_inst[1:0]!=11, SHALL give o_format=0, o_illegal=1, o_immediate=0.
REQ-016 Immediates SHALL be: I {inst[31:20]}; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; U {inst[31:12],12'b0}.
REQ-017 I, S, B, J and U values SHALL be sign-extended from their top bit to XLEN; for XLEN=64, U-type SHALL replicate inst[31] into bits 63:32.
REQ-018 CSR-imm SHALL be inst[19:15], zero-extended to XLEN; R-type SHALL produce immediate 0, never X.
REQ-019 Decode SHALL be performed before storage; the buffer holds immediate, format and illegal flag per entry.
REQ-020 Latency SHALL be 1 cycle: an instruction accepted at edge N appears at the outputs after edge N when the buffer was empty.
REQ-021 The buffer SHALL be a DEPTH-entry FIFO with read and write pointers wrapping modulo DEPTH, and an occupancy counter of width log2(DEPTH)+1.
REQ-022 A push SHALL occur iff i_valid and o_ready; a pop SHALL occur iff o_valid and i_ready.
REQ-023 o_ready SHALL equal (occupancy < DEPTH) and not i_rst; it SHALL NOT depend combinationally on i_ready.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; at full, pushes are blocked regardless of pops.
REQ-025 o_valid SHALL equal (occupancy != 0); outputs SHALL hold stable while o_valid is high and i_ready is low.
REQ-026 Entries SHALL be delivered in acceptance order, with no loss or duplication.
REQ-027 o_illegal_count SHALL increment on each push of an illegal instruction and SHALL saturate at 255.

Reset
REQ-028 While i_rst is high: occupancy=0, pointers=0, o_valid=0, o_ready=0, o_immediate=0, o_format=0, o_illegal=0, o_illegal_count=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries at the next edge; no push is accepted in that cycle.
REQ-030 The first push SHALL be accepted in the first cycle after i_rst is deasserted.

Verification
REQ-031 XLEN=32, i_ready=1: push 0xFFF00093, then 0xFE112E23, then 0xFE000CE3 -> 0xFFFFFFFF/I, 0xFFFFFFFC/S, 0xFFFFFFF8/B, each one cycle after acceptance.
REQ-032 XLEN=32: push 0x123452B7 -> 0x12345000/U; push 0x300FD073 -> 0x0000001F, o_format[6]=1.
REQ-033 XLEN=64: push 0x800002B7 -> 0xFFFFFFFF80000000/U; push 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
REQ-034 DEPTH=2, i_ready=0: push three instructions back-to-back -> o_ready low after the second push, third held upstream; raise i_ready -> all three emitted in order with no bubble.
REQ-035 Push 0x00000000 300 times -> o_illegal=1, o_format=0, o_immediate=0, o_illegal_count saturates at 255.
REQ-036 Buffer holding 2 entries, assert i_rst for one cycle -> o_valid=0, count=0 next cycle; a new push appears alone one cycle after reset is released.
